// File: rtl/sjpll_rstseq_if.sv
// sjpll_rstseq_if: the signal bundle between the PLL reset/lock sequencer and
// its surroundings (the PLL wrapper and the core reset tree).
//
// Signals:
//   pll_locked  - PLL locked output, asynchronous to refclk
//   relock_req  - single-cycle request to re-reset the PLL
//   pll_rst     - active-high reset to the PLL
//   core_rst_n  - active-low reset to the core clock domains
//   ready       - high while the sequencer is in RUN
//   lock_lost   - sticky flag, set when lock drops while running
//   retry_count - saturating count of lock timeouts
//
// Modports:
//   master - the environment side: drives pll_locked and relock_req
//   slave  - the sequencer side: drives the resets and the status outputs
interface sjpll_rstseq_if;
  logic       pll_locked;
  logic       relock_req;
  logic       pll_rst;
  logic       core_rst_n;
  logic       ready;
  logic       lock_lost;
  logic [3:0] retry_count;

  modport master (
    output pll_locked,
    output relock_req,
    input  pll_rst,
    input  core_rst_n,
    input  ready,
    input  lock_lost,
    input  retry_count
  );

  modport slave (
    input  pll_locked,
    input  relock_req,
    output pll_rst,
    output core_rst_n,
    output ready,
    output lock_lost,
    output retry_count
  );
endinterface

// File: rtl/sjpll_rstseq.sv
// sjpll_rstseq: PLL reset and lock sequencer on the PLL reference clock.
// It pulses the PLL reset, waits for lock with a timeout-and-retry loop,
// qualifies lock stability, then releases the core reset. Losing lock while
// running puts the core back into reset.
//
// Ports:
//   refclk - the only clock (PLL reference clock)
//   rst_n  - asynchronous active-low reset
//   bus    - sjpll_rstseq_if slave modport (pll_locked, relock_req in;
//            pll_rst, core_rst_n, ready, lock_lost, retry_count out)
//
// Parameters:
//   PLL_RST_CYCLES     - width of the pll_rst pulse in refclk cycles (>=1)
//   LOCK_STABLE_CYCLES - consecutive locked cycles required before release (>=1)
//   LOCK_TIMEOUT       - cycles in WAIT_LOCK before a retry (>=2)
//   CNT_W              - width of the shared counter
module sjpll_rstseq #(
  parameter int unsigned PLL_RST_CYCLES     = 16,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned LOCK_TIMEOUT       = 1000000,
  parameter int unsigned CNT_W              = 20
) (
  input  logic          refclk,
  input  logic          rst_n,
  sjpll_rstseq_if.slave bus
);

  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

  state_t           state_r;
  state_t           next_state_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_next_s;
  logic             sync1_r;
  logic             sync2_r;
  logic             locked_s;
  logic [3:0]       retry_r;
  logic             retry_inc_s;
  logic             lost_r;
  logic             lost_set_s;
  logic             lost_clr_s;
  logic             pll_rst_r;
  logic             run_r;

  // Two-flop synchroniser bringing the asynchronous locked signal onto refclk.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= bus.pll_locked;
      sync2_r <= sync1_r;
    end
  end

  assign locked_s = sync2_r;

  // Next-state, shared-counter and flag-update decode.
  always_comb begin
    next_state_s = state_r;
    retry_inc_s  = 1'b0;
    lost_set_s   = 1'b0;
    lost_clr_s   = 1'b0;

    if (bus.relock_req) begin
      // Relock outranks everything, including a timeout on the same cycle,
      // so it never counts as a retry.
      next_state_s = RESET_PLL;
      lost_clr_s   = 1'b1;
    end else begin
      case (state_r)
        RESET_PLL: begin
          if (cnt_r == RST_LAST) begin
            next_state_s = WAIT_LOCK;
          end else begin
            next_state_s = RESET_PLL;
          end
        end
        WAIT_LOCK: begin
          if (locked_s) begin
            next_state_s = STABLE;
          end else if (cnt_r == TIMEOUT_LAST) begin
            next_state_s = RESET_PLL;
            retry_inc_s  = 1'b1;
          end else begin
            next_state_s = WAIT_LOCK;
          end
        end
        STABLE: begin
          // A single unlocked cycle drops back to WAIT_LOCK, which restarts
          // both the timeout and the full qualification window.
          if (!locked_s) begin
            next_state_s = WAIT_LOCK;
          end else if (cnt_r == STABLE_LAST) begin
            next_state_s = RUN;
          end else begin
            next_state_s = STABLE;
          end
        end
        RUN: begin
          if (!locked_s) begin
            next_state_s = WAIT_LOCK;
            lost_set_s   = 1'b1;
          end else begin
            next_state_s = RUN;
          end
        end
        default: begin
          next_state_s = RESET_PLL;
        end
      endcase
    end

    // The counter restarts on every state change and on relock (which may
    // re-enter RESET_PLL from RESET_PLL itself); RUN has nothing to time.
    if (bus.relock_req || (next_state_s != state_r)) begin
      cnt_next_s = {CNT_W{1'b0}};
    end else if (state_r != RUN) begin
      cnt_next_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  // State, counter, sticky flags and registered outputs.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= RESET_PLL;
      cnt_r     <= {CNT_W{1'b0}};
      retry_r   <= 4'd0;
      lost_r    <= 1'b0;
      pll_rst_r <= 1'b1;
      run_r     <= 1'b0;
    end else begin
      state_r <= next_state_s;
      cnt_r   <= cnt_next_s;
      if (retry_inc_s && (retry_r != 4'd15)) begin
        retry_r <= retry_r + 4'd1;
      end else begin
        retry_r <= retry_r;
      end
      if (lost_clr_s) begin
        lost_r <= 1'b0;
      end else if (lost_set_s) begin
        lost_r <= 1'b1;
      end else begin
        lost_r <= lost_r;
      end
      // Outputs are decoded from the next state so they change on the
      // same edge as the state register.
      pll_rst_r <= (next_state_s == RESET_PLL);
      run_r     <= (next_state_s == RUN);
    end
  end

  assign bus.pll_rst     = pll_rst_r;
  assign bus.core_rst_n  = run_r;
  assign bus.ready       = run_r;
  assign bus.lock_lost   = lost_r;
  assign bus.retry_count = retry_r;

endmodule

// File: tb/tb_sjpll_rstseq.sv
// tb_sjpll_rstseq: self-checking bench for sjpll_rstseq with
// PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT=32, CNT_W=8.
// A table of {inputs, cycle count, expected outputs} records is stepped one
// edge at a time; the expected record is queued after the last edge of each
// entry and compared against the outputs on the following falling edge.
// Reset behaviour is checked by hand-written sequences.
module tb_sjpll_rstseq;

  typedef struct {
    logic       lk;
    logic       rq;
    int         n;
    logic       prst;
    logic       run;
    logic       lost;
    logic [3:0] retry;
    string      name;
  } vec_t;

  logic refclk;
  logic rst_n;
  int   total;
  int   passed;
  vec_t tbl[$];
  vec_t sb[$];

  sjpll_rstseq_if bus ();

  sjpll_rstseq #(
    .PLL_RST_CYCLES    (4),
    .LOCK_STABLE_CYCLES(8),
    .LOCK_TIMEOUT      (32),
    .CNT_W             (8)
  ) dut (
    .refclk(refclk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial refclk = 1'b0;
  always #5 refclk = ~refclk;

  task automatic check_out(input vec_t e);
    logic [7:0] act;
    logic [7:0] req;
    act = {bus.pll_rst, bus.core_rst_n, bus.ready, bus.lock_lost, bus.retry_count};
    req = {e.prst, e.run, e.run, e.lost, e.retry};
    total = total + 1;
    if (act === req) begin
      passed = passed + 1;
    end else begin
      $display("FAIL %s: pll_rst,core_rst_n,ready,lock_lost,retry_count got %b required %b",
               e.name, act, req);
    end
  endtask

  function automatic void add(input logic lk, input logic rq, input int n,
                              input logic prst, input logic run, input logic lost,
                              input logic [3:0] retry, input string name);
    vec_t v;
    v.lk = lk; v.rq = rq; v.n = n;
    v.prst = prst; v.run = run; v.lost = lost; v.retry = retry;
    v.name = name;
    tbl.push_back(v);
  endfunction

  task automatic step(input logic lk, input logic rq, input logic chk, input vec_t e);
    bus.pll_locked = lk;
    bus.relock_req = rq;
    @(posedge refclk);
    #1;
    if (chk) sb.push_back(e);
  endtask

  task automatic run_table();
    for (int i = 0; i < tbl.size(); i++) begin
      for (int c = 0; c < tbl[i].n; c++) begin
        step(tbl[i].lk, (c == 0) ? tbl[i].rq : 1'b0, (c == tbl[i].n - 1), tbl[i]);
      end
    end
    bus.relock_req = 1'b0;
    @(negedge refclk);
    #1;
  endtask

  // Scoreboard: compare queued expectations mid-cycle, away from the active edge.
  always @(negedge refclk) begin
    if (sb.size() != 0) check_out(sb.pop_front());
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached with %0d checks done", total);
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t r;
    logic [3:0] sat;
    total = 0;
    passed = 0;
    rst_n = 1'b0;
    bus.pll_locked = 1'b0;
    bus.relock_req = 1'b0;

    // Reset state while rst_n is held low.
    repeat (3) @(posedge refclk);
    #1;
    r.prst = 1'b1; r.run = 1'b0; r.lost = 1'b0; r.retry = 4'd0; r.name = "reset_state";
    check_out(r);
    @(negedge refclk);
    rst_n = 1'b1;

    // Timeout and retry from reset release.
    add(1'b0, 1'b0, 3,  1'b1, 1'b0, 1'b0, 4'd0, "rst_pulse_e3");
    add(1'b0, 1'b0, 1,  1'b0, 1'b0, 1'b0, 4'd0, "rst_pulse_fall_e4");
    add(1'b0, 1'b0, 31, 1'b0, 1'b0, 1'b0, 4'd0, "wait_lock_e35");
    add(1'b0, 1'b0, 1,  1'b1, 1'b0, 1'b0, 4'd1, "timeout1");
    add(1'b0, 1'b0, 3,  1'b1, 1'b0, 1'b0, 4'd1, "retry_pulse");
    add(1'b0, 1'b0, 1,  1'b0, 1'b0, 1'b0, 4'd1, "retry_pulse_end");
    // Lock acquisition: ready at edge 11 after first high sample.
    add(1'b1, 1'b0, 10, 1'b0, 1'b0, 1'b0, 4'd1, "lock_e10");
    add(1'b1, 1'b0, 1,  1'b0, 1'b1, 1'b0, 4'd1, "lock_ready_e11");
    // Lock loss in RUN, then recovery keeps lock_lost.
    add(1'b0, 1'b0, 2,  1'b0, 1'b1, 1'b0, 4'd1, "loss_e2");
    add(1'b0, 1'b0, 1,  1'b0, 1'b0, 1'b1, 4'd1, "loss_e3");
    add(1'b1, 1'b0, 10, 1'b0, 1'b0, 1'b1, 4'd1, "relock_e10");
    add(1'b1, 1'b0, 1,  1'b0, 1'b1, 1'b1, 4'd1, "relock_run");
    // relock_req in RUN, on the timeout cycle, and during RESET_PLL.
    add(1'b0, 1'b1, 1,  1'b1, 1'b0, 1'b0, 4'd1, "relock_req_run");
    add(1'b0, 1'b0, 3,  1'b1, 1'b0, 1'b0, 4'd1, "relock_pulse");
    add(1'b0, 1'b0, 1,  1'b0, 1'b0, 1'b0, 4'd1, "relock_pulse_end");
    add(1'b0, 1'b0, 31, 1'b0, 1'b0, 1'b0, 4'd1, "wait_before_collide");
    add(1'b0, 1'b1, 1,  1'b1, 1'b0, 1'b0, 4'd1, "relock_on_timeout");
    add(1'b0, 1'b0, 2,  1'b1, 1'b0, 1'b0, 4'd1, "pulse_cnt2");
    add(1'b0, 1'b1, 1,  1'b1, 1'b0, 1'b0, 4'd1, "relock_in_reset");
    add(1'b0, 1'b0, 1,  1'b1, 1'b0, 1'b0, 4'd1, "restart_1");
    add(1'b0, 1'b0, 1,  1'b1, 1'b0, 1'b0, 4'd1, "restart_2");
    add(1'b0, 1'b0, 1,  1'b1, 1'b0, 1'b0, 4'd1, "restart_3");
    add(1'b0, 1'b0, 1,  1'b0, 1'b0, 1'b0, 4'd1, "restart_end");
    // One-cycle lock glitch while STABLE at cnt 5 forces full requalification.
    add(1'b1, 1'b0, 6,  1'b0, 1'b0, 1'b0, 4'd1, "stable_e6");
    add(1'b0, 1'b0, 1,  1'b0, 1'b0, 1'b0, 4'd1, "glitch_e7");
    add(1'b1, 1'b0, 3,  1'b0, 1'b0, 1'b0, 4'd1, "glitch_e10");
    add(1'b1, 1'b0, 7,  1'b0, 1'b0, 1'b0, 4'd1, "requal_e17");
    add(1'b1, 1'b0, 1,  1'b0, 1'b1, 1'b0, 4'd1, "requal_run_e18");
    // Lose lock, then time out repeatedly until retry_count saturates.
    add(1'b0, 1'b0, 3,  1'b0, 1'b0, 1'b1, 4'd1, "sat_loss");
    add(1'b0, 1'b0, 31, 1'b0, 1'b0, 1'b1, 4'd1, "sat_wait");
    add(1'b0, 1'b0, 1,  1'b1, 1'b0, 1'b1, 4'd2, "timeout2");
    add(1'b0, 1'b0, 3,  1'b1, 1'b0, 1'b1, 4'd2, "timeout2_pulse");
    add(1'b0, 1'b0, 1,  1'b0, 1'b0, 1'b1, 4'd2, "timeout2_end");
    for (int i = 3; i <= 20; i++) begin
      sat = (i > 15) ? 4'd15 : 4'(i);
      add(1'b0, 1'b0, 32, 1'b1, 1'b0, 1'b1, sat, $sformatf("timeout%0d", i));
      add(1'b0, 1'b0, 4,  1'b0, 1'b0, 1'b1, sat, $sformatf("timeout%0d_end", i));
    end
    // Reach STABLE ahead of the mid-operation reset.
    add(1'b1, 1'b0, 5,  1'b0, 1'b0, 1'b1, 4'd15, "stable_before_rst");
    run_table();

    // Asynchronous reset in STABLE, checked with no clock edge in between.
    rst_n = 1'b0;
    #1;
    r.prst = 1'b1; r.run = 1'b0; r.lost = 1'b0; r.retry = 4'd0; r.name = "async_reset";
    check_out(r);
    @(negedge refclk);
    rst_n = 1'b1;

    // Sequencing restarts with lock already present: RUN at edge 13.
    tbl.delete();
    add(1'b1, 1'b0, 3, 1'b1, 1'b0, 1'b0, 4'd0, "restart_pulse_e3");
    add(1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 4'd0, "restart_fall_e4");
    add(1'b1, 1'b0, 8, 1'b0, 1'b0, 1'b0, 4'd0, "restart_e12");
    add(1'b1, 1'b0, 1, 1'b0, 1'b1, 1'b0, 4'd0, "restart_run_e13");
    run_table();

    @(negedge refclk);
    #1;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/sjpll_rstseq.md
# sjpll_rstseq

PLL reset and lock sequencer; it drives the PLL wrapper's `rst` input and consumes its `locked` output. It pulses the PLL reset, waits for lock with a timeout-and-retry loop, and qualifies lock stability before releasing the core reset. If lock is lost, it returns the core to reset. It sits in the top-level clocking block on the PLL reference clock, which is the only clock this block uses.

## Interface
- `PLL_RST_CYCLES`, default 16: width of the `pll_rst` pulse in refclk cycles; must be ≥1.
- `LOCK_STABLE_CYCLES`, default 1024: number of consecutive locked cycles required before release; must be ≥1.
- `LOCK_TIMEOUT`, default 1000000: number of cycles spent in WAIT_LOCK before the sequencer retries; must be ≥2.
- `CNT_W`, default 20: width of the shared counter; every cycle parameter above must be < 2^CNT_W.

- `refclk`  in  1  the single clock (PLL reference clock).
- `rst_n`  in  1  asynchronous, active-low reset.
- `pll_locked`  in  1  PLL `locked` output; asynchronous to `refclk`.
- `relock_req`  in  1  single-cycle synchronous request to re-reset the PLL.
- `pll_rst`  out  1  active-high reset to the PLL.
- `core_rst_n`  out  1  active-low reset to the core clock domains.
- `ready`  out  1  high while in RUN.
- `lock_lost`  out  1  sticky flag; set when lock drops while in RUN.
- `retry_count`  out  4  number of lock timeouts; saturates at 15.

## Operation
- **Synchroniser.** `pll_locked` passes through a 2-flop synchroniser that resets to 0. Its output, `locked_s`, is the only lock signal the FSM uses.
- **Counter.** One CNT_W counter `cnt` is shared by all states. It clears on every state change.
- **Output decode.** All outputs are registered and update on the same edge as the state:
  - `pll_rst` = (state == RESET_PLL).
  - `core_rst_n` = `ready` = (state == RUN).
- **RESET_PLL.** `cnt` increments each cycle. When `cnt == PLL_RST_CYCLES-1`, go to WAIT_LOCK.
- **WAIT_LOCK.**
  - If `locked_s` = 1, go to STABLE.
  - Otherwise `cnt` increments. When `cnt == LOCK_TIMEOUT-1` and `locked_s` = 0, go to RESET_PLL and increment `retry_count` (saturating).
- **STABLE.**
  - If `locked_s` = 0, go to WAIT_LOCK. This resets the timeout and does not change `retry_count`.
  - Otherwise `cnt` increments. When `cnt == LOCK_STABLE_CYCLES-1` and `locked_s` = 1, go to RUN.
- **RUN.** If `locked_s` = 0, go to WAIT_LOCK and set `lock_lost`.
- **relock_req.** This has the highest priority in every state.
  - Go to RESET_PLL with `cnt` cleared, and clear `lock_lost`.
  - `retry_count` does not increment, even if a timeout falls on the same cycle.
  - A `relock_req` during RESET_PLL restarts the full pulse.
- **Clearing.** `retry_count` and `lock_lost` clear only on `rst_n` (and `lock_lost` also on `relock_req`). A successful lock does not clear them.

## Timing
- **Reset values** (while `rst_n` is low, applied asynchronously): state RESET_PLL, `cnt` = 0, `pll_rst` = 1, `core_rst_n` = 0, `ready` = 0, `lock_lost` = 0, `retry_count` = 0, synchroniser flops = 0.
- **Reset release.** `pll_rst` stays high for exactly PLL_RST_CYCLES rising edges after the first edge with `rst_n` high. It falls on edge PLL_RST_CYCLES.
- **Lock latency.** Number the first edge that samples `pll_locked` = 1 in WAIT_LOCK as edge 1:
  - `locked_s` is valid after edge 2.
  - STABLE is entered at edge 3.
  - `ready` and `core_rst_n` rise at edge 3+LOCK_STABLE_CYCLES, provided `pll_locked` stays high.
- **Lock loss.** After `pll_locked` falls while in RUN, `core_rst_n` and `ready` fall on the 3rd edge.
- **Timeout.** WAIT_LOCK lasts exactly LOCK_TIMEOUT cycles without lock. `pll_rst` rises on the edge that leaves WAIT_LOCK.
- **relock_req response.** `pll_rst` rises and `ready` falls on the edge that samples `relock_req`.
- **Mid-operation reset.** Asserting `rst_n` in any state forces the reset values immediately, with no clock required.

## Test plan
All scenarios use `PLL_RST_CYCLES` = 4, `LOCK_STABLE_CYCLES` = 8, `LOCK_TIMEOUT` = 32, `CNT_W` = 8.

1. Release `rst_n` with `pll_locked` = 0 -> `pll_rst` is high for edges 1–4 and low for 32 cycles, then high again for 4 cycles with `retry_count` = 1. After 20 timeouts, `retry_count` = 15.
2. Raise `pll_locked` during WAIT_LOCK and hold it -> `core_rst_n` and `ready` go to 1 at edge 11 (edge 1 = first sample high). `retry_count` is unchanged.
3. Drop `pll_locked` low for 1 cycle at STABLE `cnt` = 5 -> FSM returns to WAIT_LOCK and `ready` stays 0. Once high again, a full 8-cycle qualification runs before `ready` = 1. `retry_count` is unchanged.
4. In RUN, drop `pll_locked` -> `ready` = `core_rst_n` = 0 and `lock_lost` = 1 on the 3rd edge. Restore lock -> RUN is re-entered after 10 edges with `lock_lost` still 1.
5. Pulse `relock_req` in RUN -> on the next edge `pll_rst` = 1, `ready` = 0, `lock_lost` = 0, and `pll_rst` is held for 4 cycles. Assert `relock_req` on the timeout cycle -> `retry_count` does not increment.
6. Assert `rst_n` low during STABLE -> asynchronously `pll_rst` = 1, `core_rst_n` = 0, `retry_count` = 0, `lock_lost` = 0. Sequencing restarts on release.
